// File: rtl/bcd_timer_ctrl.sv
// Sequencing controller for an external 2-digit BCD counter: turns start/pause/clear
// commands into load/enable/direction strobes and detects the terminal count.
module bcd_timer_ctrl #(
    parameter int TICK_DIV = 10,
    parameter int DIV_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       dir_up,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_units,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic       cnt_en,
    output logic       cnt_up,
    output logic       cnt_load,
    output logic [3:0] load_tens,
    output logic [3:0] load_units,
    output logic       done,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [3:0]       term_tens_q, term_tens_d;
    logic [3:0]       term_units_q, term_units_d;
    logic             cnt_en_q, cnt_en_d;
    logic             cnt_up_q, cnt_up_d;
    logic             cnt_load_q, cnt_load_d;
    logic [3:0]       load_tens_q, load_tens_d;
    logic [3:0]       load_units_q, load_units_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [3:0]       clamp_tens, clamp_units;
    logic             at_terminal;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign clamp_tens  = clamp_digit(preset_tens);
    assign clamp_units = clamp_digit(preset_units);

    // Terminal digits are always <= 9, so out-of-range feedback can never match.
    assign at_terminal = (tens == term_tens_q) && (units == term_units_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            term_tens_q  <= '0;
            term_units_q <= '0;
            cnt_en_q     <= 1'b0;
            cnt_up_q     <= 1'b0;
            cnt_load_q   <= 1'b0;
            load_tens_q  <= '0;
            load_units_q <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            term_tens_q  <= term_tens_d;
            term_units_q <= term_units_d;
            cnt_en_q     <= cnt_en_d;
            cnt_up_q     <= cnt_up_d;
            cnt_load_q   <= cnt_load_d;
            load_tens_q  <= load_tens_d;
            load_units_q <= load_units_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        term_tens_d  = term_tens_q;
        term_units_d = term_units_q;
        cnt_en_d     = 1'b0;
        cnt_up_d     = cnt_up_q;
        cnt_load_d   = 1'b0;
        load_tens_d  = 4'd0;
        load_units_d = 4'd0;
        done_d       = 1'b0;

        if (clear) begin
            // Abort also loads 00 so the counter is left in a known state.
            state_d    = S_IDLE;
            cnt_load_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d    = S_LOAD;
                        cnt_load_d = 1'b1;
                        cnt_up_d   = dir_up;
                        presc_d    = '0;
                        if (dir_up) begin
                            term_tens_d  = clamp_tens;
                            term_units_d = clamp_units;
                        end else begin
                            load_tens_d  = clamp_tens;
                            load_units_d = clamp_units;
                            term_tens_d  = 4'd0;
                            term_units_d = 4'd0;
                        end
                    end
                end
                S_LOAD: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (at_terminal) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (pause) begin
                        state_d = S_PAUSED;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d  = '0;
                        cnt_en_d = 1'b1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (!pause) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_PAUSED);
    end

    assign cnt_en     = cnt_en_q;
    assign cnt_up     = cnt_up_q;
    assign cnt_load   = cnt_load_q;
    assign load_tens  = load_tens_q;
    assign load_units = load_units_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign state      = state_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Closed-loop bench: bcd_timer_ctrl driving a behavioural BCD counter, checked each
// cycle against a run-activity model plus directed literal expectations.
module tb_bcd_timer_ctrl;

    localparam int TICK = 4;

    logic       clk;
    logic       rst;
    logic       start, pause, clear, dir_up;
    logic [3:0] preset_tens, preset_units;
    logic [3:0] tens, units;
    logic       cnt_en, cnt_up, cnt_load, done, busy;
    logic [3:0] load_tens, load_units;
    logic [2:0] state;

    bcd_timer_ctrl #(.TICK_DIV(TICK), .DIV_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .dir_up(dir_up), .preset_tens(preset_tens), .preset_units(preset_units),
        .tens(tens), .units(units), .cnt_en(cnt_en), .cnt_up(cnt_up),
        .cnt_load(cnt_load), .load_tens(load_tens), .load_units(load_units),
        .done(done), .busy(busy), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // External BCD counter, with a hook to inject out-of-range tens digits.
    logic [3:0] ct = 4'd0, cu = 4'd0;
    logic       inj = 1'b0;
    logic [3:0] inj_t = 4'd0;
    assign tens  = ct;
    assign units = cu;

    always @(posedge clk) begin
        if (inj) begin
            ct <= inj_t;
        end else if (cnt_load) begin
            ct <= load_tens;
            cu <= load_units;
        end else if (cnt_en) begin
            if (cnt_up) begin
                if (cu >= 4'd9) begin
                    cu <= 4'd0;
                    ct <= (ct >= 4'd9) ? 4'd0 : ct + 4'd1;
                end else begin
                    cu <= cu + 4'd1;
                end
            end else begin
                if (cu == 4'd0) begin
                    cu <= 4'd9;
                    ct <= (ct == 4'd0) ? 4'd9 : ct - 4'd1;
                end else begin
                    cu <= cu - 4'd1;
                end
            end
        end
    end

    // Reference model: a tick is due on every TICK-th cycle of running activity.
    int m_state, m_en, m_up, m_load, m_lt, m_lu, m_done, m_busy, m_tt, m_tu, m_act;
    int n_state, n_en, n_up, n_load, n_lt, n_lu, n_done, n_busy, n_tt, n_tu, n_act;
    int pt, pu;

    always_comb begin
        pt      = (preset_tens  > 4'd9) ? 9 : int'(preset_tens);
        pu      = (preset_units > 4'd9) ? 9 : int'(preset_units);
        n_state = m_state;
        n_en    = 0;
        n_up    = m_up;
        n_load  = 0;
        n_lt    = 0;
        n_lu    = 0;
        n_done  = 0;
        n_tt    = m_tt;
        n_tu    = m_tu;
        n_act   = m_act;
        if (clear) begin
            n_state = 0;
            n_load  = 1;
        end else if ((m_state == 0 || m_state == 4) && start) begin
            n_state = 1;
            n_load  = 1;
            n_up    = int'(dir_up);
            n_act   = 0;
            if (dir_up) begin
                n_tt = pt;
                n_tu = pu;
            end else begin
                n_lt = pt;
                n_lu = pu;
                n_tt = 0;
                n_tu = 0;
            end
        end else if (m_state == 1) begin
            n_state = 2;
        end else if (m_state == 2) begin
            if (int'(tens) == m_tt && int'(units) == m_tu) begin
                n_state = 4;
                n_done  = 1;
            end else if (pause) begin
                n_state = 3;
            end else begin
                n_act = m_act + 1;
                n_en  = (n_act % TICK == 0) ? 1 : 0;
            end
        end else if (m_state == 3 && !pause) begin
            n_state = 2;
        end
        n_busy = (n_state >= 1 && n_state <= 3) ? 1 : 0;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state <= 0; m_en <= 0; m_up <= 0; m_load <= 0; m_lt <= 0; m_lu <= 0;
            m_done <= 0; m_busy <= 0; m_tt <= 0; m_tu <= 0; m_act <= 0;
        end else begin
            m_state <= n_state; m_en <= n_en; m_up <= n_up; m_load <= n_load;
            m_lt <= n_lt; m_lu <= n_lu; m_done <= n_done; m_busy <= n_busy;
            m_tt <= n_tt; m_tu <= n_tu; m_act <= n_act;
        end
    end

    always @(negedge clk) begin
        if (rst && chk_en) begin
            chk("state", state, m_state);
            chk("cnt_en", cnt_en, m_en);
            chk("cnt_up", cnt_up, m_up);
            chk("cnt_load", cnt_load, m_load);
            chk("load_tens", load_tens, m_lt);
            chk("load_units", load_units, m_lu);
            chk("done", done, m_done);
            chk("busy", busy, m_busy);
            chk("en_load_excl", cnt_en & cnt_load, 0);
        end
    end

    // Event log for the directed checks.
    int cyc = 0;
    int en_q[$];
    int done_cnt = 0, done_cyc = 0, ld_cyc = 0;
    int ld_t = 0, ld_u = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (cnt_en) en_q.push_back(cyc);
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (cnt_load) begin
                ld_t   <= int'(load_tens);
                ld_u   <= int'(load_units);
                ld_cyc <= cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic d, input logic [3:0] t, input logic [3:0] u);
        dir_up       = d;
        preset_tens  = t;
        preset_units = u;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int k = 0;
        while (state !== 3'd4 && k < max) begin
            tick();
            k++;
        end
        chk({name, "_timeout"}, (k < max) ? 1 : 0, 1);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ticks(input string name, input int target, input int max);
        int k = 0;
        while (en_q.size() < target && k < max) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({name, "_tick_timeout"}, (k < max) ? 1 : 0, 1);
    endtask

    int base, d0, bad, t_rel, n_before;

    initial begin
        rst = 1'b1; start = 0; pause = 0; clear = 0; dir_up = 0;
        preset_tens = 0; preset_units = 0;
        #2 rst = 1'b0;
        repeat (3) tick();
        chk("rst_state", state, 0);
        chk("rst_outs", {cnt_en, cnt_up, cnt_load, load_tens, load_units, done, busy}, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        chk_en = 1'b1;
        tick();

        // 1: down run from 12
        base = en_q.size(); d0 = done_cnt;
        start_run(1'b0, 4'd1, 4'd2);
        wait_done("t1", 200);
        chk("t1_load_tens", ld_t, 1);
        chk("t1_load_units", ld_u, 2);
        chk("t1_ticks", en_q.size() - base, 12);
        bad = 0;
        for (int i = base + 1; i < en_q.size(); i++) if (en_q[i] - en_q[i-1] != TICK) bad++;
        chk("t1_tick_spacing", bad, 0);
        chk("t1_counter", {ct, cu}, 8'h00);
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_state", state, 4);
        chk("t1_busy", busy, 0);

        // 2: up run to 05, twice
        for (int r = 0; r < 2; r++) begin
            base = en_q.size(); d0 = done_cnt;
            start_run(1'b1, 4'd0, 4'd5);
            wait_done("t2", 100);
            chk("t2_load", {ld_t[3:0], ld_u[3:0]}, 8'h00);
            chk("t2_cnt_up", cnt_up, 1);
            chk("t2_ticks", en_q.size() - base, 5);
            chk("t2_counter", {ct, cu}, 8'h05);
            chk("t2_done_pulses", done_cnt - d0, 1);
        end

        // 3: pause after the 2nd tick of a down run from 30
        base = en_q.size();
        start_run(1'b0, 4'd3, 4'd0);
        wait_ticks("t3", base + 2, 100);
        pause = 1'b1;
        n_before = en_q.size();
        repeat (10) tick();
        chk("t3_paused_state", state, 3);
        chk("t3_no_tick_paused", en_q.size(), n_before);
        pause = 1'b0;
        t_rel = cyc;
        wait_done("t3", 400);
        chk("t3_resume_latency", en_q[base + 2] - t_rel, 1 + TICK);
        chk("t3_ticks", en_q.size() - base, 30);
        chk("t3_counter", {ct, cu}, 8'h00);

        // 4: clear together with start mid-run
        base = en_q.size();
        start_run(1'b0, 4'd2, 4'd0);
        wait_ticks("t4", base + 3, 100);
        d0 = done_cnt;
        clear = 1'b1; start = 1'b1;
        tick();
        chk("t4_state", state, 0);
        chk("t4_load", cnt_load, 1);
        chk("t4_load_val", {load_tens, load_units}, 8'h00);
        chk("t4_busy", busy, 0);
        clear = 1'b0; start = 1'b0;
        repeat (4) tick();
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_idle", state, 0);

        // 5: preset 00 down, then clamped preset F3
        base = en_q.size();
        start_run(1'b0, 4'd0, 4'd0);
        wait_done("t5a", 20);
        chk("t5a_ticks", en_q.size() - base, 0);
        chk("t5a_done_latency", done_cyc - ld_cyc, 2);
        base = en_q.size();
        start_run(1'b0, 4'hF, 4'd3);
        @(negedge clk);
        #1;
        chk("t5b_load", {ld_t[3:0], ld_u[3:0]}, 8'h93);
        wait_done("t5b", 500);
        chk("t5b_ticks", en_q.size() - base, 93);

        // 6: asynchronous reset mid-run
        start_run(1'b0, 4'd5, 4'd0);
        repeat (20) tick();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t6_state", state, 0);
        chk("t6_outs", {cnt_en, cnt_up, cnt_load, load_tens, load_units, done, busy}, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        tick();
        base = en_q.size();
        start_run(1'b0, 4'd0, 4'd3);
        wait_done("t6", 50);
        chk("t6_ticks", en_q.size() - base, 3);

        // Randomised commands, presets and out-of-range feedback
        for (int i = 0; i < 3000; i++) begin
            start        = ($urandom % 10 == 0);
            pause        = ($urandom % 5 == 0);
            clear        = ($urandom % 60 == 0);
            dir_up       = $urandom % 2;
            preset_tens  = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom % 3);
            preset_units = 4'($urandom % 16);
            inj          = ($urandom % 80 == 0);
            inj_t        = 4'($urandom_range(10, 15));
            tick();
        end
        start = 0; pause = 0; clear = 0; inj = 0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
